aes_key_round_mem: RTL
======================

# aes_key_round_mem

Key expansion and round-key store for the AES core. On `init` it expands a 128- or 256-bit cipher key into all round keys, one round key per clock, and holds them in an internal register file. It then serves `round_key` combinationally for whatever `round` index the cipher or decipher datapath presents. It sits directly upstream of `aes_decipher_block`: that block's `round` output drives this block's `round` input, and this block's `round_key` drives its `round_key` input.

## Interface
Parameters:
- `AES_128_BIT_KEY`, 1'h0: `keylen` encoding for AES-128.
- `AES_256_BIT_KEY`, 1'h1: `keylen` encoding for AES-256.
- `AES128_ROUNDS`, 4'ha: last round index for AES-128.
- `AES256_ROUNDS`, 4'he: last round index for AES-256.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `init`  in  1  start expansion; sampled only in IDLE.
- `key`  in  256  cipher key. AES-128 uses `key[255:128]`; the lower half is ignored.
- `keylen`  in  1  key length select; sampled when `init` is accepted.
- `round`  in  4  round-key index to read.
- `round_key`  out  128  round key `round`; combinational read.
- `ready`  out  1  high when idle and the stored keys are valid for the last accepted key.

The block has one clock; reset is asynchronous and active-low.

## Operation
- Storage:
  - `key_mem[0..14]`, each 128 bits.
  - `keylen_reg`.
  - `round_ctr_reg`, 4 bits.
  - `rcon_reg`, 8 bits.
  - `prev_key0_reg` (key r-2) and `prev_key1_reg` (key r-1).
  - FSM state register.
- FSM states: IDLE, INIT, GENERATE, DONE.
- IDLE with `init`=1 → INIT:
  - clear `ready`;
  - latch `keylen` and `key`;
  - set `rcon_reg` = 8'h8d, so that its first update yields 8'h01.
- INIT → GENERATE:
  - AES-128: write `key_mem[0]` = `key[255:128]`; set `prev_key1` to the same value; `round_ctr` = 1.
  - AES-256: write `key_mem[0]` = `key[255:128]` and `key_mem[1]` = `key[127:0]`; `prev_key0`/`prev_key1` = these two halves; `round_ctr` = 2.
- GENERATE: produce key r = `round_ctr_reg` each cycle from a single 32-bit S-box lookup.
  - Let `t` = last word (bits [31:0]) of `prev_key1`.
  - AES-128: `t'` = SubWord(RotWord(t)) ^ {rcon,24'h0}; w0 = prev_key1.w0 ^ `t'`; wi = w(i-1) ^ prev_key1.wi.
  - AES-256, even r: same as AES-128, except the base is `prev_key0` instead of `prev_key1`.
  - AES-256, odd r: `t'` = SubWord(t), no rotate and no rcon; base is `prev_key0`.
  - rcon update: rcon = xtime(rcon) (reduction poly 8'h1b), applied every AES-128 round and on even AES-256 rounds only.
  - Each cycle: write `key_mem[r]`, shift `prev_key0` ← `prev_key1` and `prev_key1` ← new key, increment `round_ctr`.
  - When r equals the last round index (10 or 14), go to DONE.
- DONE → IDLE: set `ready`=1.
- `round_key` = `key_mem[round]` if `round` ≤ 14, else 128'h0.
- The read port is always live. Values are meaningful only while `ready`=1.
- `init` asserted outside IDLE is ignored; it is not queued.
- Inputs `key` and `keylen` may change freely after `init` is accepted.

## Timing
- Reset (asynchronous, any time):
  - `ready`=1, state IDLE;
  - all `key_mem` entries, `prev_key*`, `round_ctr`, `rcon` cleared to 0;
  - `round_key` therefore reads 0.
- Reset during expansion aborts it; no partial keys survive.
- Let `init` be accepted at edge E0. Then `ready` reads 0 from E0.
- AES-128:
  - `key_mem[0]` written at E1;
  - `key_mem[1..10]` written at E2..E11;
  - `ready`=1 after E12, i.e. 12-cycle latency.
- AES-256:
  - `key_mem[0..1]` written at E1;
  - `key_mem[2..14]` written at E2..E14;
  - `ready`=1 after E15, i.e. 15-cycle latency.
- A new `init` can be accepted on the same edge at which `ready` is observed high.
- Re-expansion with AES-128 leaves `key_mem[11..14]` stale. This is legal because AES-128 never reads them.
- `round_key` follows `round` combinationally with zero cycle latency. This is required because the decipher datapath consumes the key in the same cycle it presents `round`.

## Structure
- Shared package `aes_pkg` holds:
  - keylen encodings;
  - `AES128_ROUNDS`/`AES256_ROUNDS`;
  - FSM state encodings;
  - the `xtime`/gm2 function, also used by the cipher and decipher blocks.
- One sub-module: `aes_sbox`, the forward S-box, 32-bit word in and out, instantiated once.
- Expected size: about 200–300 lines of RTL.

## Test plan
- Reset behaviour: hold `reset_n`=0 → `ready`=1, and `round_key`=0 for every `round` 0..15.
- FIPS-197 C.1, AES-128:
  - stimulus: key 000102030405060708090a0b0c0d0e0f, `init` for 1 cycle;
  - `ready` returns after 12 cycles;
  - `round`=10 → 13111d7fe3944a17f307a78b4d2b30c5;
  - `round`=0 → the key itself.
- FIPS-197 Appendix A.1, AES-128:
  - stimulus: key 2b7e151628aed2a6abf7158809cf4f3c;
  - `round`=1 → a0fafe1788542cb123a339392a6c7605;
  - `round`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 C.3, AES-256:
  - stimulus: key 000102…1f;
  - `ready` after 15 cycles;
  - `round`=1 → 101112131415161718191a1b1c1d1e1f;
  - `round`=14 → 24fc79ccbf0979e9371ac23c6d68de36.
- Busy and abort:
  - pulse `init` again mid-expansion → ignored; results equal the first key;
  - assert `reset_n`=0 at cycle 5 of expansion → `ready`=1, all keys read 0; a fresh `init` then completes correctly.
- Back-to-back and out-of-range read:
  - AES-256 expansion, then AES-128 expansion `init` on the cycle `ready` rises → rounds 0..10 match C.1;
  - `round`=15 → 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key store and the cipher/decipher blocks.
// Contents:
//   - keylen encodings (AES-128 / AES-256)
//   - last round index for each key length
//   - key-expansion FSM state encoding
//   - xtime (GF(2^8) multiply by 2, reduction polynomial 0x11b)
package aes_pkg;

  localparam logic       AES_128_BIT_KEY = 1'h0;
  localparam logic       AES_256_BIT_KEY = 1'h1;

  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  typedef enum logic [1:0] {
    KS_IDLE     = 2'd0,
    KS_INIT     = 2'd1,
    KS_GENERATE = 2'd2,
    KS_DONE     = 2'd3
  } key_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to each byte of a 32-bit word (SubWord).
// Ports:
//   sword      in  32  word to substitute
//   new_sword  out 32  byte-wise S-box result
module aes_sbox (
  input  logic [31:0] sword,
  output logic [31:0] new_sword
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign new_sword = {SBOX[sword[31:24]], SBOX[sword[23:16]],
                      SBOX[sword[15:8]],  SBOX[sword[7:0]]};

endmodule

// File: rtl/aes_key_round_mem.sv
// AES key expansion and round-key store.
// Expands a 128/256-bit cipher key into all round keys (one per clock) and
// serves round_key combinationally for the presented round index.
// Ports:
//   clk        in   1    system clock
//   reset_n    in   1    asynchronous active-low reset
//   init       in   1    start expansion (honoured only in IDLE)
//   key        in   256  cipher key; AES-128 uses key[255:128]
//   keylen     in   1    0 = AES-128, 1 = AES-256
//   round      in   4    round-key index to read
//   round_key  out  128  key_mem[round], or 0 when round > 14
//   ready      out  1    idle and stored keys valid
//
// state        | meaning
// -------------+-----------------------------------------------------------
// KS_IDLE      | keys stable, waiting for init
// KS_INIT      | write the key itself as round key 0 (and 1 for AES-256)
// KS_GENERATE  | derive round key round_ctr, one per cycle
// KS_DONE      | last key written; raise ready on the way back to IDLE
module aes_key_round_mem
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready
);

  key_state_e   state_q, state_d;
  logic         ready_q, ready_d;
  logic         keylen_q, keylen_d;
  logic [255:0] key_q, key_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] prev_key0_q, prev_key0_d;
  logic [127:0] prev_key1_q, prev_key1_d;
  logic [127:0] key_mem_q [0:14];
  logic [127:0] key_mem_d [0:14];

  logic         is_256;
  logic         odd_256;
  logic         use_rcon;
  logic [3:0]   last_round;
  logic [7:0]   rcon_nxt;
  logic [31:0]  t_word;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic [31:0]  t_prime;
  logic [127:0] base_key;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] new_key;

  assign is_256     = (keylen_q == AES_256_BIT_KEY);
  assign last_round = is_256 ? AES256_ROUNDS : AES128_ROUNDS;

  // Odd AES-256 rounds take SubWord only: no rotate, no rcon.
  assign odd_256  = is_256 && round_ctr_q[0];
  assign use_rcon = !odd_256;
  assign rcon_nxt = xtime(rcon_q);

  assign t_word   = prev_key1_q[31:0];
  assign sbox_in  = odd_256 ? t_word : {t_word[23:0], t_word[31:24]};

  aes_sbox u_sbox (
    .sword     (sbox_in),
    .new_sword (sbox_out)
  );

  // rcon is pre-advanced: the value used this round is the updated one, which
  // is why IDLE loads 0x8d (xtime(0x8d) = 0x01).
  assign t_prime  = sbox_out ^ (use_rcon ? {rcon_nxt, 24'h0} : 32'h0);
  assign base_key = is_256 ? prev_key0_q : prev_key1_q;
  assign w0       = base_key[127:96] ^ t_prime;
  assign w1       = base_key[95:64]  ^ w0;
  assign w2       = base_key[63:32]  ^ w1;
  assign w3       = base_key[31:0]   ^ w2;
  assign new_key  = {w0, w1, w2, w3};

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    keylen_d    = keylen_q;
    key_d       = key_q;
    round_ctr_d = round_ctr_q;
    rcon_d      = rcon_q;
    prev_key0_d = prev_key0_q;
    prev_key1_d = prev_key1_q;
    key_mem_d   = key_mem_q;

    case (state_q)
      KS_IDLE: begin
        if (init) begin
          state_d  = KS_INIT;
          ready_d  = 1'b0;
          keylen_d = keylen;
          key_d    = key;
          rcon_d   = 8'h8d;
        end
      end

      KS_INIT: begin
        key_mem_d[0] = key_q[255:128];
        if (is_256) begin
          key_mem_d[1] = key_q[127:0];
          prev_key0_d  = key_q[255:128];
          prev_key1_d  = key_q[127:0];
          round_ctr_d  = 4'd2;
        end else begin
          prev_key1_d  = key_q[255:128];
          round_ctr_d  = 4'd1;
        end
        state_d = KS_GENERATE;
      end

      KS_GENERATE: begin
        key_mem_d[round_ctr_q] = new_key;
        prev_key0_d            = prev_key1_q;
        prev_key1_d            = new_key;
        round_ctr_d            = round_ctr_q + 4'd1;
        if (use_rcon) begin
          rcon_d = rcon_nxt;
        end
        if (round_ctr_q == last_round) begin
          state_d = KS_DONE;
        end
      end

      KS_DONE: begin
        ready_d = 1'b1;
        state_d = KS_IDLE;
      end

      default: begin
        state_d = KS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= KS_IDLE;
      ready_q     <= 1'b1;
      keylen_q    <= 1'b0;
      key_q       <= '0;
      round_ctr_q <= '0;
      rcon_q      <= '0;
      prev_key0_q <= '0;
      prev_key1_q <= '0;
      for (int i = 0; i < 15; i++) begin
        key_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      keylen_q    <= keylen_d;
      key_q       <= key_d;
      round_ctr_q <= round_ctr_d;
      rcon_q      <= rcon_d;
      prev_key0_q <= prev_key0_d;
      prev_key1_q <= prev_key1_d;
      for (int i = 0; i < 15; i++) begin
        key_mem_q[i] <= key_mem_d[i];
      end
    end
  end

  assign round_key = (round <= 4'd14) ? key_mem_q[round] : 128'h0;
  assign ready     = ready_q;

endmodule
